// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI3-style slave backed by a word-addressed on-chip SRAM.
// Read (AR/R) and write (AW/W/B) run as independent FSMs. Each direction has
// one outstanding transaction. FIXED and INCR bursts of up to 16 beats are
// supported; any non-FIXED burst type is treated as INCR.
// Beats outside [BASE_ADDR, BASE_ADDR + 4*DEPTH) return SLVERR. Out-of-range
// read beats return zero data. Out-of-range write beats are dropped.
// A read sample and a write commit to the same word in one cycle return the
// old word (read-first).
// Optional build macro AXI_SLV_DELAY_EN: an 8-bit LFSR inserts 0-3 idle cycles
// before each arready, awready, wready and rvalid assertion.
// Ports:
//   aclk, aresetn               clock, asynchronous active-low reset
//   ar*/arvalid/arready         read address channel
//   rid/rdata/rresp/rlast/...   read data channel
//   aw*/awvalid/awready         write address channel
//   wid/wdata/wstrb/wlast/...   write data channel
//   bid/bresp/bvalid/bready     write response channel
module axi_sram_slave #(
   parameter int unsigned DEPTH     = 16384,
   parameter logic [31:0] BASE_ADDR = 32'h1c00_0000,
   parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic [3:0]  arid,
   input  logic [31:0] araddr,
   input  logic [7:0]  arlen,
   input  logic [2:0]  arsize,
   input  logic [1:0]  arburst,
   input  logic [1:0]  arlock,
   input  logic [3:0]  arcache,
   input  logic [2:0]  arprot,
   input  logic        arvalid,
   output logic        arready,
   output logic [3:0]  rid,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rlast,
   output logic        rvalid,
   input  logic        rready,
   input  logic [3:0]  awid,
   input  logic [31:0] awaddr,
   input  logic [7:0]  awlen,
   input  logic [2:0]  awsize,
   input  logic [1:0]  awburst,
   input  logic [1:0]  awlock,
   input  logic [3:0]  awcache,
   input  logic [2:0]  awprot,
   input  logic        awvalid,
   output logic        awready,
   input  logic [3:0]  wid,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wlast,
   input  logic        wvalid,
   output logic        wready,
   output logic [3:0]  bid,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);
   localparam int unsigned IW      = $clog2(DEPTH);
   localparam logic [31:0] DEPTH_W = 32'(DEPTH);

   typedef enum logic {RIdle, RData} r_state_e;
   typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;

   logic [31:0] mem [DEPTH];

   function automatic logic in_range(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE_ADDR;
      return (a >= BASE_ADDR) && ((off >> 2) < DEPTH_W);
   endfunction

   function automatic logic [IW-1:0] word_idx(input logic [31:0] a);
      return IW'((a - BASE_ADDR) >> 2);
   endfunction

   // FIXED keeps the address; every other burst type increments (wraps mod 2^32).
   function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] burst);
      return (burst == 2'b00) ? a : a + 32'd4;
   endfunction

   logic sig_unused;
   assign sig_unused = ^{arlen[7:4], arsize, arlock, arcache, arprot, awlen[7:4], awsize,
                         awlock, awcache, awprot, wid, LFSR_SEED};

   // Stall length loaded at each wait point; always zero unless the delay feature is built.
   logic [1:0] stall;
`ifdef AXI_SLV_DELAY_EN
   logic [7:0] lfsr;
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) lfsr <= LFSR_SEED;
      else          lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end
   assign stall = lfsr[1:0];
`else
   assign stall = 2'b00;
`endif

   // ---------------- read channel ----------------
   r_state_e    r_state_q, r_state_d;
   logic [31:0] r_addr_q, r_addr_d, r_sample_addr;
   logic [3:0]  r_cnt_q, r_cnt_d, r_len_q, r_len_d;
   logic [1:0]  r_burst_q, r_burst_d, r_wait_q, r_wait_d;
   logic        arready_d, rvalid_d, rlast_d, r_sample;
   logic [31:0] rdata_d;
   logic [3:0]  rid_d;
   logic [1:0]  rresp_d;

   always_comb begin
      r_state_d     = r_state_q;
      r_addr_d      = r_addr_q;
      r_cnt_d       = r_cnt_q;
      r_len_d       = r_len_q;
      r_burst_d     = r_burst_q;
      r_wait_d      = (r_wait_q != 2'd0) ? r_wait_q - 2'd1 : 2'd0;
      arready_d     = arready;
      rvalid_d      = rvalid;
      rdata_d       = rdata;
      rid_d         = rid;
      rresp_d       = rresp;
      rlast_d       = rlast;
      r_sample      = 1'b0;
      r_sample_addr = r_addr_q;
      unique case (r_state_q)
         RIdle: begin
            if (arvalid && arready) begin
               r_state_d     = RData;
               r_addr_d      = araddr;
               r_cnt_d       = 4'd0;
               r_len_d       = arlen[3:0];
               r_burst_d     = arburst;
               rid_d         = arid;
               arready_d     = 1'b0;
               r_wait_d      = stall;
               r_sample_addr = araddr;
               r_sample      = (stall == 2'd0);
            end else begin
               arready_d = (r_wait_d == 2'd0);
            end
         end
         RData: begin
            if (rvalid && rready) begin
               rvalid_d = 1'b0;
               rlast_d  = 1'b0;
               r_wait_d = stall;
               if (rlast) begin
                  r_state_d = RIdle;
                  arready_d = (stall == 2'd0);
               end else begin
                  r_addr_d      = next_addr(r_addr_q, r_burst_q);
                  r_cnt_d       = r_cnt_q + 4'd1;
                  r_sample_addr = r_addr_d;
                  r_sample      = (stall == 2'd0);
               end
            end else if (!rvalid) begin
               r_sample = (r_wait_d == 2'd0);
            end
         end
      endcase
      // Beat data is captured into the output registers when rvalid rises, so it holds
      // stable under backpressure.
      if (r_sample) begin
         rvalid_d = 1'b1;
         rdata_d  = in_range(r_sample_addr) ? mem[word_idx(r_sample_addr)] : 32'd0;
         rresp_d  = in_range(r_sample_addr) ? 2'b00 : 2'b10;
         rlast_d  = (r_cnt_d == r_len_d);
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state_q <= RIdle;
         r_addr_q  <= '0;
         r_cnt_q   <= '0;
         r_len_q   <= '0;
         r_burst_q <= '0;
         r_wait_q  <= '0;
         arready   <= 1'b0;
         rvalid    <= 1'b0;
         rdata     <= '0;
         rid       <= '0;
         rresp     <= '0;
         rlast     <= 1'b0;
      end else begin
         r_state_q <= r_state_d;
         r_addr_q  <= r_addr_d;
         r_cnt_q   <= r_cnt_d;
         r_len_q   <= r_len_d;
         r_burst_q <= r_burst_d;
         r_wait_q  <= r_wait_d;
         arready   <= arready_d;
         rvalid    <= rvalid_d;
         rdata     <= rdata_d;
         rid       <= rid_d;
         rresp     <= rresp_d;
         rlast     <= rlast_d;
      end
   end

   // ---------------- write channel ----------------
   w_state_e    w_state_q, w_state_d;
   logic [31:0] w_addr_q, w_addr_d;
   logic [3:0]  w_cnt_q, w_cnt_d, w_len_q, w_len_d;
   logic [1:0]  w_burst_q, w_burst_d, w_wait_q, w_wait_d;
   logic        err_q, err_d, mem_we;
   logic        awready_d, wready_d, bvalid_d;
   logic [3:0]  bid_d;
   logic [1:0]  bresp_d;

   always_comb begin
      w_state_d = w_state_q;
      w_addr_d  = w_addr_q;
      w_cnt_d   = w_cnt_q;
      w_len_d   = w_len_q;
      w_burst_d = w_burst_q;
      w_wait_d  = (w_wait_q != 2'd0) ? w_wait_q - 2'd1 : 2'd0;
      err_d     = err_q;
      awready_d = awready;
      wready_d  = wready;
      bvalid_d  = bvalid;
      bid_d     = bid;
      bresp_d   = bresp;
      mem_we    = 1'b0;
      unique case (w_state_q)
         WIdle: begin
            if (awvalid && awready) begin
               w_state_d = WData;
               w_addr_d  = awaddr;
               w_cnt_d   = 4'd0;
               w_len_d   = awlen[3:0];
               w_burst_d = awburst;
               bid_d     = awid;
               awready_d = 1'b0;
               w_wait_d  = stall;
               wready_d  = (stall == 2'd0);
            end else begin
               awready_d = (w_wait_d == 2'd0);
            end
         end
         WData: begin
            if (wvalid && wready) begin
               mem_we = in_range(w_addr_q);
               // wlast must coincide with the counted final beat; the count alone ends the burst.
               if (!in_range(w_addr_q) || (wlast != (w_cnt_q == w_len_q))) err_d = 1'b1;
               if (w_cnt_q == w_len_q) begin
                  w_state_d = WResp;
                  wready_d  = 1'b0;
                  bvalid_d  = 1'b1;
                  bresp_d   = err_d ? 2'b10 : 2'b00;
               end else begin
                  w_addr_d = next_addr(w_addr_q, w_burst_q);
                  w_cnt_d  = w_cnt_q + 4'd1;
                  w_wait_d = stall;
                  wready_d = (stall == 2'd0);
               end
            end else if (!wready) begin
               wready_d = (w_wait_d == 2'd0);
            end
         end
         WResp: begin
            if (bvalid && bready) begin
               w_state_d = WIdle;
               bvalid_d  = 1'b0;
               err_d     = 1'b0;
               w_wait_d  = stall;
               awready_d = (stall == 2'd0);
            end
         end
         default: w_state_d = WIdle;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         w_state_q <= WIdle;
         w_addr_q  <= '0;
         w_cnt_q   <= '0;
         w_len_q   <= '0;
         w_burst_q <= '0;
         w_wait_q  <= '0;
         err_q     <= 1'b0;
         awready   <= 1'b0;
         wready    <= 1'b0;
         bvalid    <= 1'b0;
         bid       <= '0;
         bresp     <= '0;
      end else begin
         w_state_q <= w_state_d;
         w_addr_q  <= w_addr_d;
         w_cnt_q   <= w_cnt_d;
         w_len_q   <= w_len_d;
         w_burst_q <= w_burst_d;
         w_wait_q  <= w_wait_d;
         err_q     <= err_d;
         awready   <= awready_d;
         wready    <= wready_d;
         bvalid    <= bvalid_d;
         bid       <= bid_d;
         bresp     <= bresp_d;
      end
   end

   // Memory array is deliberately not reset.
   always_ff @(posedge aclk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) mem[word_idx(w_addr_q)][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed self-checking bench for axi_sram_slave (default build, no stalls).
module tb_axi_sram_slave;
   localparam logic [31:0] BASE = 32'h1c00_0000;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic [3:0]  arid, awid, wid, rid, bid;
   logic [31:0] araddr, awaddr, wdata, rdata;
   logic [7:0]  arlen, awlen;
   logic [2:0]  arsize, awsize, arprot, awprot;
   logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
   logic [3:0]  arcache, awcache, wstrb;
   logic        arvalid, arready, rlast, rvalid, rready;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

   axi_sram_slave dut (
      .aclk(aclk), .aresetn(aresetn),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
      .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
      .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
      .awready(awready), .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .wvalid(wvalid), .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid),
      .bready(bready)
   );

   always #5 aclk = ~aclk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic sig_of(input int which);
      case (which)
         0:       return arready;
         1:       return awready;
         2:       return wready;
         3:       return rvalid;
         default: return bvalid;
      endcase
   endfunction

   // Returns on a falling edge where the selected signal is high (handshake on next rise).
   task automatic wait_sig(input int which, input string tag);
      for (int n = 0; n < 50; n++) begin
         @(negedge aclk);
         if (sig_of(which)) return;
      end
      check({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   logic [31:0] wbuf [16];
   logic [31:0] rbuf [16];
   logic [1:0]  rrbuf [16];
   logic        rlbuf [16];
   logic [3:0]  ridbuf;

   task automatic axi_write(input logic [31:0] addr, input logic [3:0] len,
                            input logic [1:0] burst, input logic [3:0] strb,
                            input logic [3:0] id, input int bad_last,
                            output logic [1:0] resp);
      awaddr = addr; awlen = {4'h0, len}; awburst = burst; awid = id; awvalid = 1'b1;
      wait_sig(1, "aw");
      @(posedge aclk); #1 awvalid = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         wdata = wbuf[i]; wstrb = strb; wlast = (i == int'(len)) != (i == bad_last);
         wvalid = 1'b1;
         wait_sig(2, "w");
         @(posedge aclk); #1;
      end
      wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
      wait_sig(4, "b");
      resp = bresp;
      check("bid", 32'(bid), 32'(id));
      @(posedge aclk); #1 bready = 1'b0;
      check("awready_back", 32'(awready), 32'd1);
   endtask

   task automatic axi_read(input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input logic [3:0] id, input int stall_beat);
      logic [31:0] sd;
      logic [7:0]  sc;
      araddr = addr; arlen = {4'h0, len}; arburst = burst; arid = id; arvalid = 1'b1;
      rready = 1'b1;
      wait_sig(0, "ar");
      @(posedge aclk); #1 arvalid = 1'b0;
      check("arready_drop", 32'(arready), 32'd0);
      check("rvalid_t1", 32'(rvalid), 32'd1);
      for (int i = 0; i <= int'(len); i++) begin
         wait_sig(3, "r");
         if (i == stall_beat) begin
            rready = 1'b0;
            sd = rdata;
            sc = {rvalid, rid, rresp, rlast};
            repeat (5) begin
               @(negedge aclk);
               check("r_hold_data", rdata, sd);
               check("r_hold_ctl", 32'({rvalid, rid, rresp, rlast}), 32'(sc));
            end
            rready = 1'b1;
         end
         rbuf[i] = rdata; rrbuf[i] = rresp; rlbuf[i] = rlast; ridbuf = rid;
         @(posedge aclk); #1;
      end
      rready = 1'b0;
      check("arready_back", 32'(arready), 32'd1);
      check("rvalid_off", 32'(rvalid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] br, br2;
      {arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready} = '0;
      {awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid} = '0;
      {wid, wdata, wstrb, wlast, wvalid, bready} = '0;

      // Reset state
      #1;
      check("rst_arready", 32'(arready), 32'd0);
      check("rst_awready", 32'(awready), 32'd0);
      check("rst_rvalid", 32'(rvalid), 32'd0);
      check("rst_bvalid", 32'(bvalid), 32'd0);
      repeat (2) @(negedge aclk);
      aresetn = 1'b1;
      #1 check("arready_before_edge", 32'(arready), 32'd0);
      @(posedge aclk); #1;
      check("arready_up", 32'(arready), 32'd1);
      check("awready_up", 32'(awready), 32'd1);
      check("wready_idle", 32'(wready), 32'd0);

      // Single write then single read at word 0
      wbuf[0] = 32'hDEADBEEF;
      axi_write(BASE, 4'd0, 2'b01, 4'hF, 4'd1, -1, br);
      check("w0_bresp", 32'(br), 32'd0);
      axi_read(BASE, 4'd0, 2'b01, 4'd3, -1);
      check("r0_data", rbuf[0], 32'hDEADBEEF);
      check("r0_rid", 32'(ridbuf), 32'd3);
      check("r0_rlast", 32'(rlbuf[0]), 32'd1);
      check("r0_rresp", 32'(rrbuf[0]), 32'd0);

      // INCR burst write / read of 4
      for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
      axi_write(BASE + 32'h10, 4'd3, 2'b01, 4'hF, 4'd7, -1, br);
      check("incr_bresp", 32'(br), 32'd0);
      axi_read(BASE + 32'h10, 4'd3, 2'b01, 4'd4, -1);
      for (int i = 0; i < 4; i++) begin
         check("incr_data", rbuf[i], 32'(i + 1));
         check("incr_rlast", 32'(rlbuf[i]), 32'(i == 3));
      end

      // Byte strobes
      wbuf[0] = 32'h11223344;
      axi_write(BASE + 32'h20, 4'd0, 2'b01, 4'hF, 4'd2, -1, br);
      wbuf[0] = 32'hAABBCCDD;
      axi_write(BASE + 32'h20, 4'd0, 2'b01, 4'b0101, 4'd2, -1, br);
      axi_read(BASE + 32'h20, 4'd0, 2'b01, 4'd0, -1);
      check("strb_data", rbuf[0], 32'h11BB33DD);

      // Out of range and boundaries
      axi_read(32'h0000_0000, 4'd0, 2'b01, 4'd1, -1);
      check("oor_lo_data", rbuf[0], 32'd0);
      check("oor_lo_resp", 32'(rrbuf[0]), 32'd2);
      axi_read(BASE - 32'd4, 4'd0, 2'b01, 4'd1, -1);
      check("oor_below_resp", 32'(rrbuf[0]), 32'd2);
      wbuf[0] = 32'h12345678;
      axi_write(BASE + 32'h0001_0000, 4'd0, 2'b01, 4'hF, 4'd6, -1, br);
      check("oor_w_bresp", 32'(br), 32'd2);
      axi_read(BASE, 4'd0, 2'b01, 4'd0, -1);
      check("oor_w_no_alias", rbuf[0], 32'hDEADBEEF);
      wbuf[0] = 32'hCAFEF00D;
      axi_write(BASE + 32'h0000_FFFC, 4'd0, 2'b01, 4'hF, 4'd6, -1, br);
      check("top_w_bresp", 32'(br), 32'd0);
      axi_read(BASE + 32'h0000_FFFC, 4'd1, 2'b01, 4'd0, -1);
      check("top_r_data", rbuf[0], 32'hCAFEF00D);
      check("top_r_resp", 32'(rrbuf[0]), 32'd0);
      check("past_top_resp", 32'(rrbuf[1]), 32'd2);
      check("past_top_data", rbuf[1], 32'd0);

      // FIXED burst
      wbuf[0] = 32'd0;
      axi_write(BASE + 32'h34, 4'd0, 2'b01, 4'hF, 4'd0, -1, br);
      wbuf[0] = 32'hA; wbuf[1] = 32'hB; wbuf[2] = 32'hC;
      axi_write(BASE + 32'h30, 4'd2, 2'b00, 4'hF, 4'd0, -1, br);
      check("fixed_bresp", 32'(br), 32'd0);
      axi_read(BASE + 32'h30, 4'd1, 2'b00, 4'd0, -1);
      check("fixed_r0", rbuf[0], 32'hC);
      check("fixed_r1", rbuf[1], 32'hC);
      axi_read(BASE + 32'h30, 4'd1, 2'b01, 4'd0, -1);
      check("fixed_next_word", rbuf[1], 32'd0);

      // wlast protocol errors, sticky error cleared by B handshake
      wbuf[0] = 32'h5; wbuf[1] = 32'h6;
      axi_write(BASE + 32'h50, 4'd1, 2'b01, 4'hF, 4'd0, 0, br);
      check("early_wlast_bresp", 32'(br), 32'd2);
      axi_write(BASE + 32'h50, 4'd1, 2'b01, 4'hF, 4'd0, 1, br);
      check("missing_wlast_bresp", 32'(br), 32'd2);
      axi_write(BASE + 32'h50, 4'd1, 2'b01, 4'hF, 4'd0, -1, br);
      check("clean_after_err", 32'(br), 32'd0);

      // Read backpressure concurrent with a write burst
      for (int i = 0; i < 4; i++) wbuf[i] = 32'h40 + 32'(i);
      fork
         axi_read(BASE + 32'h10, 4'd3, 2'b01, 4'd9, 1);
         axi_write(BASE + 32'h40, 4'd3, 2'b01, 4'hF, 4'd8, -1, br2);
      join
      for (int i = 0; i < 4; i++) check("bp_data", rbuf[i], 32'(i + 1));
      check("bp_rid", 32'(ridbuf), 32'd9);
      check("conc_bresp", 32'(br2), 32'd0);
      axi_read(BASE + 32'h40, 4'd3, 2'b01, 4'd0, -1);
      for (int i = 0; i < 4; i++) check("conc_data", rbuf[i], 32'h40 + 32'(i));

      // Reset mid-transaction
      araddr = BASE; arlen = 8'd7; arburst = 2'b01; arid = 4'd2; arvalid = 1'b1; rready = 1'b0;
      wait_sig(0, "ar_mid");
      @(posedge aclk); #1 arvalid = 1'b0;
      awaddr = BASE + 32'h100; awlen = 8'd3; awburst = 2'b01; awvalid = 1'b1;
      wait_sig(1, "aw_mid");
      @(posedge aclk); #1 awvalid = 1'b0;
      @(negedge aclk);
      check("pre_rst_rvalid", 32'(rvalid), 32'd1);
      check("pre_rst_wready", 32'(wready), 32'd1);
      aresetn = 1'b0;
      #1;
      check("mid_rst_rvalid", 32'(rvalid), 32'd0);
      check("mid_rst_wready", 32'(wready), 32'd0);
      check("mid_rst_rdata", rdata, 32'd0);
      check("mid_rst_arready", 32'(arready), 32'd0);
      @(negedge aclk);
      aresetn = 1'b1;
      @(posedge aclk); #1;
      check("post_rst_arready", 32'(arready), 32'd1);
      check("post_rst_awready", 32'(awready), 32'd1);
      check("post_rst_rvalid", 32'(rvalid), 32'd0);
      axi_read(BASE, 4'd0, 2'b01, 4'd0, -1);
      check("mem_kept", rbuf[0], 32'hDEADBEEF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI3-style single-port-per-direction slave that answers the CPU's AXI master interface: AR/R, AW/W/B.
- Backs a word-addressed on-chip SRAM array. Serves as the instruction/data memory model and the bring-up target for the core and its bridge.
- Read and write channels run independent FSMs, with one outstanding transaction per direction.
- Supports FIXED and INCR bursts of up to 16 beats.

Parameters:
- DEPTH, 16384: memory size in 32-bit words; must be a power of 2.
- BASE_ADDR, 32'h1c00_0000: byte address of word 0.
- LFSR_SEED, 8'hA5: stall-generator seed, used only with the optional feature.

Ports:
aclk  in  1  clock
aresetn  in  1  async active-low reset
arid  in  4  read ID
araddr  in  32  read byte address
arlen  in  8  beats-1; only [3:0] honoured
arsize  in  3  ignored; full word always returned
arburst  in  2  00 FIXED, 01 INCR, others treated as INCR
arlock/arcache/arprot  in  2/4/3  ignored
arvalid  in  1  AR valid
arready  out  1  AR ready
rid  out  4  echoed arid
rdata  out  32  read data
rresp  out  2  00 OKAY, 10 SLVERR
rlast  out  1  final beat
rvalid  out  1  R valid
rready  in  1  R ready
awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot  in  4/32/8/3/2/2/4/3  same rules as AR
awvalid  in  1  AW valid
awready  out  1  AW ready
wid  in  4  ignored
wdata  in  32  write data
wstrb  in  4  byte enables
wlast  in  1  final W beat
wvalid  in  1  W valid
wready  out  1  W ready
bid  out  4  echoed awid
bresp  out  2  00 OKAY, 10 SLVERR
bvalid  out  1  B valid
bready  in  1  B ready

Behaviour:
- Reset (aresetn=0, asynchronous): every output register clears to 0, including arready, awready, wready, rvalid, rlast, rdata, rid, rresp, bvalid, bid, bresp.
  - Both FSMs go to IDLE.
  - Memory contents are not reset.
  - Reset mid-transaction drops the transaction silently.
- Word index = (addr - BASE_ADDR) >> 2.
  - A beat is out of range when addr < BASE_ADDR or index >= DEPTH.
  - Low 2 address bits are ignored.
- Read FSM has states R_IDLE, R_DATA.
  - R_IDLE: arready=1, registered; it first rises the cycle after reset release.
  - AR handshake at edge T: latch arid, address, len, burst; arready drops to 0. rvalid=1 from T+1 with beat 0.
  - R_DATA: on each rvalid&rready, the next beat is presented the following cycle and rvalid stays high. Address +4 for INCR, unchanged for FIXED.
  - rlast=1 when beat count == arlen[3:0]. The handshake of that beat returns to R_IDLE, with arready=1 the next cycle.
  - Out-of-range beat: rdata=0, rresp=10. Otherwise rdata=mem[index], rresp=00.
  - rdata/rid/rresp/rlast hold stable while rvalid&!rready.
- Write FSM has states W_IDLE, W_DATA, W_RESP.
  - W_IDLE: awready=1, wready=0. W beats are never accepted before AW.
  - AW handshake: latch awid, address, len, burst → W_DATA with wready=1.
  - Each wvalid&wready beat writes the bytes of mem[index] enabled by wstrb. Out-of-range beats are dropped and set the sticky error.
  - Beat count == awlen[3:0] ends the burst → W_RESP.
  - Protocol error: wlast=0 on the counted final beat, or wlast=1 earlier, sets the sticky error. The burst still ends on the count.
  - W_RESP: bvalid=1, bid=latched awid, bresp=10 if sticky error else 00. The bready handshake → W_IDLE and clears the sticky error.
- Read and write proceed concurrently.
  - A read sample and a write commit to the same word in the same cycle: the read returns the old data (read-first).
- Address increments wrap modulo 2^32. No 4KB boundary check.

Optional Feature:
- AXI_SLV_DELAY_EN defined: an 8-bit Fibonacci LFSR (taps 8,6,5,4), seeded with LFSR_SEED at reset, advances every cycle.
  - Before asserting arready, awready, each wready, and each rvalid beat, the block waits lfsr[1:0] cycles (0-3), sampled on state entry or after the previous handshake.
  - An asserted valid or ready stays asserted until its handshake.
- Undefined: zero stall; latencies exactly as in Behaviour.

Test Plan:
- Reset then single read: mem[0]=32'hDEADBEEF; AR araddr=32'h1c00_0000, arlen=0, arid=3 → at T+1 rvalid=1, rdata=DEADBEEF, rid=3, rlast=1, rresp=00; arready=1 again the cycle after the R handshake.
- INCR write burst: awaddr=32'h1c00_0010, awlen=3, data 1..4, wstrb=F, wlast on beat 3 → bresp=00; a read burst of 4 returns 1,2,3,4 with rlast only on beat 3.
- Byte strobe: mem word = 32'h11223344; write 32'hAABBCCDD with wstrb=4'b0101 → readback 32'h11BB33DD.
- Out of range: araddr=32'h0000_0000 → rdata=0, rresp=10. Write to BASE_ADDR+4*DEPTH → bresp=10 and memory unchanged.
- Backpressure and concurrency: hold rready=0 for 5 cycles mid-burst while a write burst runs → R outputs stable, no beat lost, write completes with bresp=00. Drop aresetn mid-burst → all valids 0 immediately; after release arready/awready=1.
- With AXI_SLV_DELAY_EN: 100 random single reads/writes → data correct; every stall is ≤3 cycles; no ready or valid deasserts before its handshake.
